// File: rtl/seq_divider16_if.sv
// seq_divider16_if
//   Groups the start/done handshake, operands and results of the sequential
//   divider into one bundle.
//   master : drives start, a, b; observes q, r, busy, done, divzero
//   slave  : the divider itself
//   Signals:
//     start   request to start a division
//     a, b    dividend / divisor
//     q, r    quotient / remainder registers
//     busy    division in progress
//     done    one-cycle result-valid pulse
//     divzero last accepted divisor was zero
interface seq_divider16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             divzero;

  modport master (
    output start, a, b,
    input  q, r, busy, done, divzero
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, divzero
  );
endinterface

// File: rtl/seq_divider16.sv
// seq_divider16
//   Sequential 16-bit unsigned restoring divider, one quotient bit per clock.
//   Each iteration performs a 17-bit trial subtraction R + ~{0,b} + 1 using
//   the carry-lookahead structure of the datapath adder (four 4-bit groups
//   plus one extra bit).
//   Ports:
//     clk   single clock, rising edge
//     nrst  synchronous reset, active-low
//     bus   seq_divider16_if slave modport (start, a, b, q, r, busy, done,
//           divzero)
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nrst,
  seq_divider16_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 17-bit subtract x - y as x + ~y + 1, carries generated by 4-bit
  // lookahead groups with a group-level lookahead across them. Returns
  // {carry_out, diff[15:0]}; bit 16 of the difference is never kept because
  // an accepted difference is always below the divisor.
  function automatic logic [16:0] cla_sub17(input logic [16:0] x,
                                            input logic [16:0] y);
    logic [16:0] g;
    logic [16:0] p;
    logic [17:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    g = x & ~y;
    p = x ^ ~y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    c[0]  = 1'b1;
    c[4]  = gg[0] | (gp[0] & c[0]);
    c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
    c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c[0]);
    c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (&gp & c[0]);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[17] = g[16] | (p[16] & c[16]);
    return {c[17], p[15:0] ^ c[15:0]};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // R < b between iterations, so 16 bits hold it
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_sh;         // shifted partial remainder, 17 bits
  logic [WIDTH:0]   sub_res;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign rem_sh    = {rem_q, dvd_q[WIDTH-1]};
  assign sub_res   = cla_sub17(rem_sh, {1'b0, dvs_q});
  assign no_borrow = sub_res[WIDTH];
  assign rem_next  = no_borrow ? sub_res[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_next  = {dvd_q[WIDTH-2:0], no_borrow};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // The done cycle doubles as an idle slot so a held start yields one
        // result every 17 cycles. A zero divisor is only taken from true
        // IDLE, which keeps done from pulsing on consecutive cycles.
        if (state_q == S_DONE) state_d = S_IDLE;
        if (bus.start) begin
          if (bus.b != '0) begin
            dvd_d   = bus.a;
            dvs_d   = bus.b;
            rem_d   = '0;
            cnt_d   = 4'd15;
            dz_d    = 1'b0;
            state_d = S_RUN;
          end else if (state_q == S_IDLE) begin
            q_d     = '1;
            r_d     = bus.a;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          q_d     = quo_next;
          r_d     = rem_next;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.r       = r_q;
  assign bus.divzero = dz_q;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);

endmodule
